// File: rtl/clk_gate_pkg.sv
// ----------------------------------------------------------------------------
// clk_gate_pkg
//   Shared definitions for the clock-gating control slice.
//   - cg_state_t  : FSM state encoding of the activity/idle monitor
//   - ST_RECOVER  : state an illegal encoding falls back to
//   - cnt_width() : counter width needed to hold 0..max_val
// ----------------------------------------------------------------------------
package clk_gate_pkg;

    typedef enum logic [2:0] {
        ST_RUN   = 3'd0,
        ST_COUNT = 3'd1,
        ST_DRAIN = 3'd2,
        ST_OFF   = 3'd3,
        ST_WAKE  = 3'd4
    } cg_state_t;

    // Encodings 5..7 are unreachable in normal operation; if one ever
    // appears (upset, bad init) the FSM returns to the clock-running state.
    localparam cg_state_t ST_RECOVER = ST_RUN;

    // Width of a counter that must represent every value 0..max_val.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage : clk_gate_pkg

// File: rtl/cg_sat_counter.sv
// ----------------------------------------------------------------------------
// cg_sat_counter
//   Loadable / clearable up-down counter that saturates at 0 and at MAX.
//   Priority: clear > load > increment > decrement.
//
//   Ports
//     clk         : clock
//     reset_n     : asynchronous active-low reset (count -> 0)
//     i_clr       : synchronous clear to 0
//     i_load      : synchronous load of i_load_val
//     i_load_val  : value loaded when i_load is high
//     i_inc       : increment, holds at MAX
//     i_dec       : decrement, holds at 0
//     o_count     : current count
// ----------------------------------------------------------------------------
module cg_sat_counter #(
    parameter int W   = 4,
    parameter int MAX = 15
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         i_clr,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_inc,
    input  logic         i_dec,
    output logic [W-1:0] o_count
);

    localparam logic [W-1:0] LP_MAX = W'(MAX);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_inc) begin
            if (r_count != LP_MAX) r_count <= r_count + W'(1);
        end else if (i_dec) begin
            if (r_count != '0) r_count <= r_count - W'(1);
        end
    end

    assign o_count = r_count;

endmodule : cg_sat_counter

// File: rtl/activity_idle_monitor.sv
// ----------------------------------------------------------------------------
// activity_idle_monitor
//   Produces the activity enable for the dynamic clock-gating cell. After
//   IDLE_CYCLES consecutive idle samples it asks the gated logic to quiesce;
//   once the gated logic acknowledges, activity drops. Any busy source, wake
//   request or force-on re-raises activity, and the quiesce request is held
//   for a WAKE_CYCLES warm-up window before being released.
//
//   Ports
//     clk           : free-running (ungated) clock
//     reset_n       : asynchronous active-low reset
//     busy_i        : per-source busy flags (NUM_SRC bits)
//     wake_i        : wake request from the ungated domain
//     force_on_i    : override, keeps the clock running while high
//     quiesce_ack_i : gated logic is drained and safe to stop
//     quiesce_req_o : request for gated logic to drain and hold still
//     activity_o    : clock-gate enable, 1 = clock running
//     state_o       : current FSM state encoding (debug/status)
// ----------------------------------------------------------------------------
module activity_idle_monitor
    import clk_gate_pkg::*;
#(
    parameter int NUM_SRC     = 4,
    parameter int IDLE_CYCLES = 16,
    parameter int WAKE_CYCLES = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_SRC-1:0] busy_i,
    input  logic               wake_i,
    input  logic               force_on_i,
    input  logic               quiesce_ack_i,
    output logic               quiesce_req_o,
    output logic               activity_o,
    output logic [2:0]         state_o
);

    localparam int IW = cnt_width(IDLE_CYCLES);
    localparam int WW = cnt_width(WAKE_CYCLES);

    // The idle count is about to reach IDLE_CYCLES when it currently holds
    // IDLE_CYCLES-1; that edge is the one that enters DRAIN.
    localparam logic [IW-1:0] LP_IDLE_LAST = IW'(IDLE_CYCLES - 1);
    localparam logic [IW-1:0] LP_IDLE_ONE  = IW'(1);
    localparam logic [WW-1:0] LP_WAKE_LOAD = WW'(WAKE_CYCLES);
    localparam logic [WW-1:0] LP_WAKE_ONE  = WW'(1);

    cg_state_t     r_state;
    cg_state_t     w_state_next;

    logic          w_any_busy;
    logic          w_idle_clr;
    logic          w_idle_load;
    logic          w_idle_inc;
    logic          w_wake_load;
    logic          w_wake_dec;
    logic [IW-1:0] w_idle_cnt;
    logic [WW-1:0] w_wake_cnt;
    logic          w_activity;
    logic          w_quiesce_req;

    assign w_any_busy = (|busy_i) | wake_i | force_on_i;

    cg_sat_counter #(
        .W   (IW),
        .MAX (IDLE_CYCLES)
    ) u_idle_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_clr      (w_idle_clr),
        .i_load     (w_idle_load),
        .i_load_val (LP_IDLE_ONE),
        .i_inc      (w_idle_inc),
        .i_dec      (1'b0),
        .o_count    (w_idle_cnt)
    );

    cg_sat_counter #(
        .W   (WW),
        .MAX (WAKE_CYCLES)
    ) u_wake_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_clr      (1'b0),
        .i_load     (w_wake_load),
        .i_load_val (LP_WAKE_LOAD),
        .i_inc      (1'b0),
        .i_dec      (w_wake_dec),
        .o_count    (w_wake_cnt)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= ST_RUN;
        else          r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_idle_clr   = 1'b0;
        w_idle_load  = 1'b0;
        w_idle_inc   = 1'b0;
        w_wake_load  = 1'b0;
        w_wake_dec   = 1'b0;

        case (r_state)
            ST_RUN: begin
                if (w_any_busy) begin
                    w_idle_clr = 1'b1;
                end else begin
                    w_idle_load  = 1'b1;
                    w_state_next = (IDLE_CYCLES == 1) ? ST_DRAIN : ST_COUNT;
                end
            end

            ST_COUNT: begin
                if (w_any_busy) begin
                    w_idle_clr   = 1'b1;
                    w_state_next = ST_RUN;
                end else begin
                    w_idle_inc = 1'b1;
                    if (w_idle_cnt >= LP_IDLE_LAST) w_state_next = ST_DRAIN;
                end
            end

            ST_DRAIN: begin
                // Fresh activity wins over a simultaneous acknowledge.
                if (w_any_busy) begin
                    w_idle_clr   = 1'b1;
                    w_state_next = ST_RUN;
                end else if (quiesce_ack_i) begin
                    w_state_next = ST_OFF;
                end
            end

            ST_OFF: begin
                if (w_any_busy) begin
                    w_idle_clr   = 1'b1;
                    w_wake_load  = 1'b1;
                    w_state_next = ST_WAKE;
                end
            end

            ST_WAKE: begin
                // Warm-up runs to completion; idle samples are discarded.
                w_idle_clr = 1'b1;
                w_wake_dec = 1'b1;
                if (w_wake_cnt <= LP_WAKE_ONE) w_state_next = ST_RUN;
            end

            default: begin
                w_idle_clr   = 1'b1;
                w_state_next = ST_RECOVER;
            end
        endcase
    end

    // Outputs are a pure decode of the state register, so they change only
    // on clock edges (or immediately on reset) and never follow an input.
    always_comb begin
        w_activity    = 1'b1;
        w_quiesce_req = 1'b0;
        case (r_state)
            ST_DRAIN: w_quiesce_req = 1'b1;
            ST_OFF: begin
                w_activity    = 1'b0;
                w_quiesce_req = 1'b1;
            end
            ST_WAKE:  w_quiesce_req = 1'b1;
            default: begin
                w_activity    = 1'b1;
                w_quiesce_req = 1'b0;
            end
        endcase
    end

    assign activity_o    = w_activity;
    assign quiesce_req_o = w_quiesce_req;
    assign state_o       = r_state;

endmodule : activity_idle_monitor

// File: tb/tb_activity_idle_monitor.sv
module tb_activity_idle_monitor;

    localparam int NUM_SRC = 4;
    localparam int IDLE    = 4;
    localparam int WAKE    = 2;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic [NUM_SRC-1:0] busy_i = '0;
    logic               wake_i = 1'b0;
    logic               force_on_i = 1'b0;
    logic               quiesce_ack_i = 1'b0;
    logic               quiesce_req_o;
    logic               activity_o;
    logic [2:0]         state_o;

    activity_idle_monitor #(
        .NUM_SRC     (NUM_SRC),
        .IDLE_CYCLES (IDLE),
        .WAKE_CYCLES (WAKE)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .busy_i        (busy_i),
        .wake_i        (wake_i),
        .force_on_i    (force_on_i),
        .quiesce_ack_i (quiesce_ack_i),
        .quiesce_req_o (quiesce_req_o),
        .activity_o    (activity_o),
        .state_o       (state_o)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit mon_en = 1'b0;

    // Behavioural model: how many consecutive idle samples have been seen
    // since the clock was last known to be needed, whether the gated logic
    // is switched off, and how many warm-up cycles remain.
    int m_idle_run  = 0;
    int m_wake_left = 0;
    bit m_off       = 1'b0;
    bit m_any;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int m_state();
        if (m_off)             return 3;
        if (m_wake_left > 0)   return 4;
        if (m_idle_run >= IDLE) return 2;
        if (m_idle_run > 0)    return 1;
        return 0;
    endfunction

    function automatic bit m_req();
        return m_off || (m_wake_left > 0) || (m_idle_run >= IDLE);
    endfunction

    // Single compare process: advance the model with the inputs seen at the
    // edge, then check all outputs shortly after the edge.
    always @(posedge clk) begin
        m_any = (|busy_i) || wake_i || force_on_i;
        if (!reset_n) begin
            m_idle_run  = 0;
            m_wake_left = 0;
            m_off       = 1'b0;
        end else if (m_off) begin
            if (m_any) begin
                m_off       = 1'b0;
                m_wake_left = WAKE;
                m_idle_run  = 0;
            end
        end else if (m_wake_left > 0) begin
            m_wake_left = m_wake_left - 1;
            m_idle_run  = 0;
        end else if (m_any) begin
            m_idle_run = 0;
        end else if (m_idle_run >= IDLE && quiesce_ack_i) begin
            m_off = 1'b1;
        end else if (m_idle_run < IDLE) begin
            m_idle_run = m_idle_run + 1;
        end
        #1;
        if (mon_en) begin
            chk("state", 32'(state_o), 32'(m_state()));
            chk("activity", 32'(activity_o), 32'(!m_off));
            chk("quiesce_req", 32'(quiesce_req_o), 32'(m_req()));
        end
    end

    // Inputs change 2 time units after the edge, well away from sampling.
    task automatic tick(input logic [NUM_SRC-1:0] b, input logic w, input logic f, input logic a);
        busy_i        = b;
        wake_i        = w;
        force_on_i    = f;
        quiesce_ack_i = a;
        @(posedge clk);
        #2;
    endtask

    initial begin
        @(posedge clk);
        #2;
        mon_en = 1'b1;
        chk("reset_activity", 32'(activity_o), 32'd1);
        chk("reset_req", 32'(quiesce_req_o), 32'd0);
        chk("reset_state", 32'(state_o), 32'd0);
        reset_n = 1'b1;

        // Idle from reset release: request at edge 4, ack at edge 6.
        for (int i = 0; i < 3; i++) tick('0, 0, 0, 0);
        chk("edge3_req", 32'(quiesce_req_o), 32'd0);
        tick('0, 0, 0, 0);
        chk("edge4_req", 32'(quiesce_req_o), 32'd1);
        chk("edge4_state", 32'(state_o), 32'd2);
        tick('0, 0, 0, 0);
        chk("edge5_activity", 32'(activity_o), 32'd1);
        tick('0, 0, 0, 1);
        chk("edge6_activity", 32'(activity_o), 32'd0);
        chk("edge6_state", 32'(state_o), 32'd3);

        // Wake pulse from OFF: 2-cycle warm-up with request held.
        tick('0, 1, 0, 0);
        chk("wake_activity", 32'(activity_o), 32'd1);
        chk("wake_req1", 32'(quiesce_req_o), 32'd1);
        chk("wake_state", 32'(state_o), 32'd4);
        tick('0, 0, 0, 0);
        chk("wake_req2", 32'(quiesce_req_o), 32'd1);
        tick('0, 0, 0, 0);
        chk("wake_done_req", 32'(quiesce_req_o), 32'd0);
        chk("wake_done_state", 32'(state_o), 32'd0);

        // Three idle then a busy pulse: counting restarts from scratch.
        for (int i = 0; i < 3; i++) tick('0, 0, 0, 0);
        tick(4'b0100, 0, 0, 0);
        chk("busy_clear_state", 32'(state_o), 32'd0);
        for (int i = 0; i < 3; i++) tick('0, 0, 0, 0);
        chk("recount_req3", 32'(quiesce_req_o), 32'd0);
        tick('0, 0, 0, 0);
        chk("recount_req4", 32'(quiesce_req_o), 32'd1);

        // Busy and ack together in DRAIN: abort wins.
        tick(4'b0001, 0, 0, 1);
        chk("abort_state", 32'(state_o), 32'd0);
        chk("abort_activity", 32'(activity_o), 32'd1);
        chk("abort_req", 32'(quiesce_req_o), 32'd0);

        // Force-on held through 50 idle cycles, then released.
        for (int i = 0; i < 50; i++) tick('0, 0, 1, 1'($urandom_range(0, 1)));
        for (int i = 0; i < 3; i++) tick('0, 0, 0, 0);
        chk("force_rel_req3", 32'(quiesce_req_o), 32'd0);
        tick('0, 0, 0, 0);
        chk("force_rel_req4", 32'(quiesce_req_o), 32'd1);
        tick('0, 0, 0, 1);
        chk("off_again_state", 32'(state_o), 32'd3);

        // Asynchronous reset while OFF, between edges.
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_activity", 32'(activity_o), 32'd1);
        chk("async_req", 32'(quiesce_req_o), 32'd0);
        chk("async_state", 32'(state_o), 32'd0);
        tick('0, 0, 0, 0);
        reset_n = 1'b1;

        // Random traffic biased toward idle so every state is visited.
        for (int i = 0; i < 3000; i++) begin
            logic [NUM_SRC-1:0] b;
            b = '0;
            if ($urandom_range(0, 7) == 0) b = NUM_SRC'($urandom_range(1, (1 << NUM_SRC) - 1));
            reset_n = ($urandom_range(0, 299) != 0);
            tick(b,
                 1'($urandom_range(0, 15) == 0),
                 1'($urandom_range(0, 31) == 0),
                 1'($urandom_range(0, 2) == 0));
        end
        reset_n = 1'b1;
        tick('0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_activity_idle_monitor
